// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first.
// Reports the final carry (1 = no borrow on subtract) and signed overflow, with a done strobe.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] out_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovf_q;
   logic             sa_q;
   logic             sb_q;

   logic [WIDTH-1:0] b_in_d;
   logic [DIGIT:0]   digit_sum_d;
   logic [DIGIT-1:0] s_d;
   logic             c_d;
   logic [WIDTH-1:0] out_d;
   logic             start_d;
   logic             last_d;

   always_comb begin
      b_in_d      = sub ? ~b : b;
      digit_sum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      s_d         = digit_sum_d[DIGIT-1:0];
      c_d         = digit_sum_d[DIGIT];
      // New digit enters at the MSB end so the first (LSB) digit ends up at bit 0.
      out_d       = (out_q >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
      start_d     = en && (state_q == IDLE || state_q == DONE);
      last_d      = (cnt_q == CW'(NDIG - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
      end else if (start_d) begin
         a_q     <= a;
         b_q     <= b_in_d;
         carry_q <= sub;
         cnt_q   <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         sa_q    <= a[WIDTH-1];
         sb_q    <= b_in_d[WIDTH-1];
         state_q <= RUN;
      end else begin
         case (state_q)
            IDLE: begin
            end
            RUN: begin
               out_q   <= out_d;
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               carry_q <= c_d;
               cnt_q   <= cnt_q + CW'(1);
               if (last_d) begin
                  cout_q  <= c_d;
                  ovf_q   <= (sa_q == sb_q) && (s_d[DIGIT-1] != sa_q);
                  state_q <= DONE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out  = out_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance.
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       en8, sub8, cout8, ovf8, busy8, done8;
   logic [7:0] a8, b8, out8;
   logic        en16, sub16, cout16, ovf16, busy16, done16;
   logic [15:0] a16, b16, out16;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .sub(sub8), .a(a8), .b(b8),
      .out(out8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8));

   serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .en(en16), .sub(sub16), .a(a16), .b(b16),
      .out(out16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16));

   typedef struct packed {
      logic [15:0] out;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic exp_t model(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
      exp_t        r;
      logic [15:0] mask, am, bm;
      logic [16:0] sum;
      mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
      am    = a & mask;
      bm    = (s ? ~b : b) & mask;
      sum   = {1'b0, am} + {1'b0, bm} + {16'd0, s};
      r.out  = sum[15:0] & mask;
      r.cout = sum[w];
      r.ovf  = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives a start request and records what the result must be.
   task automatic start(input int w, input logic s, input logic [15:0] a, input logic [15:0] b, input exp_t e);
      if (w == 16) begin en16 = 1'b1; sub16 = s; a16 = a; b16 = b; end
      else begin en8 = 1'b1; sub8 = s; a8 = a[7:0]; b8 = b[7:0]; end
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int w, output int ticks, output int busy_n, output bit to);
      ticks = 0; busy_n = 0; to = 1'b0;
      while (!((w == 16) ? done16 : done8)) begin
         if ((w == 16) ? busy16 : busy8) busy_n++;
         tick();
         ticks++;
         if (ticks > 100) begin to = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      en8 = 0; sub8 = 0; a8 = 0; b8 = 0;
      en16 = 0; sub16 = 0; a16 = 0; b16 = 0;
      #12;
      n_cmp++;
      if ({out8, cout8, ovf8, busy8, done8} !== 12'd0) begin
         n_bad++; $display("FAIL reset8 got=%h exp=000", {out8, cout8, ovf8, busy8, done8});
      end
      n_cmp++;
      if ({out16, cout16, ovf16, busy16, done16} !== 20'd0) begin
         n_bad++; $display("FAIL reset16 got=%h exp=00000", {out16, cout16, ovf16, busy16, done16});
      end
      #5 rst = 1'b1;
      tick();
      $display("reset: outputs checked");
   endtask

   task automatic test_add_basic;
      int ticks, busy_n; bit to; exp_t e;
      start(8, 1'b0, 16'h5A, 16'h3C, '{16'h0096, 1'b0, 1'b1});
      tick();
      en8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      wait_done(8, ticks, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL add_timeout no done within bound"); end
      n_cmp++;
      if (busy_n != 8) begin n_bad++; $display("FAIL add_busy got=%0d exp=8", busy_n); end
      n_cmp++;
      if (ticks + 1 != 9) begin n_bad++; $display("FAIL add_latency got=%0d exp=9", ticks + 1); end
      n_cmp++;
      if ({out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL add_result got out=%h c=%b v=%b exp out=%h c=%b v=%b",
                           out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
      end
      tick();
      n_cmp++;
      if ({busy8, done8, out8, cout8, ovf8} !== {2'b00, e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL add_hold got busy=%b done=%b out=%h exp busy=0 done=0 out=%h",
                           busy8, done8, out8, e.out[7:0]);
      end
      $display("add 5A+3C: out=%h cout=%b ovf=%b latency=%0d busy=%0d", out8, cout8, ovf8, ticks + 1, busy_n);
   endtask

   task automatic test_sub_and_random;
      logic        s_tab [3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0]  a_tab [3] = '{8'h10, 8'h80, 8'hFF};
      logic [7:0]  b_tab [3] = '{8'h20, 8'h01, 8'h01};
      exp_t        e_tab [3] = '{'{16'h00F0, 1'b0, 1'b0}, '{16'h007F, 1'b1, 1'b1}, '{16'h0000, 1'b1, 1'b0}};
      int ticks, busy_n; bit to; exp_t e;
      logic s; logic [7:0] a, b;
      for (int i = 0; i < 9; i++) begin
         if (i < 3) begin
            s = s_tab[i]; a = a_tab[i]; b = b_tab[i];
            start(8, s, {8'h00, a}, {8'h00, b}, e_tab[i]);
         end else begin
            s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            start(8, s, {8'h00, a}, {8'h00, b}, model(8, s, {8'h00, a}, {8'h00, b}));
         end
         tick();
         en8 = 1'b0;
         wait_done(8, ticks, busy_n, to);
         e = exp_q.pop_front();
         n_cmp++;
         if (to || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
            n_bad++; $display("FAIL op8_%0d sub=%b a=%h b=%h got out=%h c=%b v=%b exp out=%h c=%b v=%b",
                              i, s, a, b, out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
         end
         $display("op8 sub=%b a=%h b=%h -> out=%h cout=%b ovf=%b", s, a, b, out8, cout8, ovf8);
         tick();
      end
   endtask

   task automatic test_wide;
      int ticks, busy_n; bit to; exp_t e;
      logic s; logic [15:0] a, b;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            s = 1'b0; a = 16'h1234; b = 16'h0FFF;
            start(16, s, a, b, '{16'h2233, 1'b0, 1'b0});
         end else begin
            s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            start(16, s, a, b, model(16, s, a, b));
         end
         tick();
         en16 = 1'b0; a16 = 16'($urandom);
         wait_done(16, ticks, busy_n, to);
         e = exp_q.pop_front();
         n_cmp++;
         if (to || busy_n != 4 || ticks + 1 != 5) begin
            n_bad++; $display("FAIL wide_timing_%0d got busy=%0d latency=%0d exp busy=4 latency=5", i, busy_n, ticks + 1);
         end
         n_cmp++;
         if ({out16, cout16, ovf16} !== {e.out, e.cout, e.ovf}) begin
            n_bad++; $display("FAIL wide_%0d sub=%b a=%h b=%h got out=%h c=%b v=%b exp out=%h c=%b v=%b",
                              i, s, a, b, out16, cout16, ovf16, e.out, e.cout, e.ovf);
         end
         $display("op16 sub=%b a=%h b=%h -> out=%h cout=%b ovf=%b", s, a, b, out16, cout16, ovf16);
         tick();
      end
   endtask

   task automatic test_back_to_back;
      int ticks, busy_n; bit to; exp_t e;
      start(8, 1'b0, 16'h01, 16'h01, '{16'h0002, 1'b0, 1'b0});
      tick();
      wait_done(8, ticks, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL b2b_first got out=%h exp out=%h", out8, e.out[7:0]);
      end
      start(8, 1'b0, 16'h7F, 16'h01, '{16'h0080, 1'b0, 1'b1});
      tick();
      n_cmp++;
      if ({busy8, done8} !== 2'b10) begin
         n_bad++; $display("FAIL b2b_no_idle got busy=%b done=%b exp busy=1 done=0", busy8, done8);
      end
      en8 = 1'b0;
      wait_done(8, ticks, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || busy_n != 8 || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL b2b_second got out=%h c=%b v=%b busy=%0d exp out=%h c=%b v=%b busy=8",
                           out8, cout8, ovf8, busy_n, e.out[7:0], e.cout, e.ovf);
      end
      $display("back-to-back: second out=%h ovf=%b", out8, ovf8);
      tick();
   endtask

   task automatic test_en_during_run;
      int ticks, busy_n; bit to; exp_t e;
      start(8, 1'b0, 16'h5A, 16'h3C, '{16'h0096, 1'b0, 1'b1});
      tick();
      en8 = 1'b0;
      repeat (3) tick();
      en8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      tick();
      en8 = 1'b0;
      wait_done(8, ticks, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || ticks + 4 != 8 || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL en_in_run got out=%h c=%b v=%b edges=%0d exp out=%h c=%b v=%b edges=8",
                           out8, cout8, ovf8, ticks + 4, e.out[7:0], e.cout, e.ovf);
      end
      tick();
      n_cmp++;
      if ({busy8, done8} !== 2'b00) begin
         n_bad++; $display("FAIL en_not_queued got busy=%b done=%b exp busy=0 done=0", busy8, done8);
      end
      $display("en during run: out=%h, no queued op", out8);
   endtask

   task automatic test_async_reset;
      int ticks, busy_n; bit to; exp_t e;
      start(8, 1'b0, 16'h5A, 16'h3C, '{16'h0096, 1'b0, 1'b1});
      tick();
      en8 = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({out8, busy8} !== {8'hC0, 1'b1}) begin
         n_bad++; $display("FAIL mid_run_partial got out=%h busy=%b exp out=c0 busy=1", out8, busy8);
      end
      void'(exp_q.pop_back());
      #3 rst = 1'b0;
      #1;
      n_cmp++;
      if ({out8, cout8, ovf8, busy8, done8} !== 12'd0) begin
         n_bad++; $display("FAIL async_clear got=%h exp=000", {out8, cout8, ovf8, busy8, done8});
      end
      #2 rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({out8, busy8, done8} !== 10'd0) begin
         n_bad++; $display("FAIL needs_fresh_en got out=%h busy=%b done=%b exp all 0", out8, busy8, done8);
      end
      start(8, 1'b1, 16'h10, 16'h20, '{16'h00F0, 1'b0, 1'b0});
      tick();
      en8 = 1'b0;
      wait_done(8, ticks, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || {out8, cout8, ovf8} !== {e.out[7:0], e.cout, e.ovf}) begin
         n_bad++; $display("FAIL after_reset got out=%h c=%b v=%b exp out=%h c=%b v=%b",
                           out8, cout8, ovf8, e.out[7:0], e.cout, e.ovf);
      end
      $display("async reset: cleared, then 10-20 -> out=%h", out8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add_basic();
      test_sub_and_random();
      test_wide();
      test_back_to_back();
      test_en_during_run();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
